nn_layer_engine: RTL and testbench
==================================

// Module: nn_layer_engine
// PURPOSE
//  Parametrised successor to the single-lane MNIST top: one binary fully-connected layer engine.
//  Owns the x/w memory ports in both phases: off-chip load via valid/ready, then an XNOR-popcount
//  pass over LANES neurons in parallel. Emits one LANES-bit result word per neuron group.
//  Sits between the off-chip loader and mem_sys (1-bit x memory, LANES-bit-wide w memory).
// PARAMETERS
//  N_IN      784  inputs per neuron (x vector length)
//  N_OUT     16   neurons in the layer; must be a multiple of LANES
//  LANES     4    neurons computed in parallel; also the w memory word width
//  X_ADDR_LEN 10  x memory address width; 2**X_ADDR_LEN >= N_IN
//  W_ADDR_LEN 20  w memory address width; 2**W_ADDR_LEN >= N_IN*N_OUT/LANES
//  ACC_W     $clog2(N_IN)+2  signed accumulator width (localparam)
// PORTS
//  clk        in  1      clock
//  rst        in  1      asynchronous reset, active-low
//  load_en    in  1      level: hold high to stay in load phase
//  ld_valid   in  1      load beat valid
//  ld_ready   out 1      load beat accepted when ld_valid&ld_ready
//  ld_sel     in  1      0 = x beat (ld_data[0] used), 1 = w beat (all LANES bits)
//  ld_data    in  LANES  load payload
//  ld_ovf     out 1      sticky: a beat was offered past memory capacity
//  start      in  1      one-cycle pulse: run the layer
//  x_we/w_we  out 1      memory write enables
//  x_addr     out X_ADDR_LEN, w_addr out W_ADDR_LEN  memory addresses
//  x_wdata    out 1, w_wdata out LANES                 memory write data
//  x_rdata    in  1, w_rdata in LANES                  memory read data, 1-cycle sync latency
//  res_valid  out 1      one-cycle pulse per neuron group
//  res_group  out $clog2(N_OUT/LANES) group index of res_data
//  res_data   out LANES  sign bits: 1 iff accumulator >= 0
//  busy       out 1      high in LOAD/RUN/DRAIN
//  compute_finish out 1  high in DONE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, ld_ovf 0, load counters 0.
//  FSM: IDLE -load_en-> LOAD; IDLE -start-> RUN; LOAD -!load_en-> IDLE;
//   RUN -(last i of last group issued)-> DRAIN; DRAIN -(1 cycle)-> DONE; DONE -start-> RUN, -load_en-> LOAD.
//  load_en and start together in IDLE/DONE: load_en wins. start outside IDLE/DONE is ignored.
//  LOAD: ld_ready = 1 while the selected counter < capacity (x: N_IN, w: N_IN*N_OUT/LANES).
//   Accepted beat: we=1 for one cycle at the counter address, counter increments. Separate x/w counters.
//   Beat at capacity: ld_ready=0, no write, ld_ovf set (cleared only by reset). Counters clear on LOAD entry.
//  RUN: per group g, i = 0..N_IN-1, one read per cycle: x_addr=i, w_addr=g*N_IN+i.
//   Data returns next cycle; lane k: acc[k] += (x_rdata == w_rdata[k]) ? +1 : -1.
//   acc cleared on the first beat of each group; no bubbles between groups.
//   res_valid fires the cycle after the last beat of group g lands: N_IN+1 cycles after that group's first address.
//   Full layer: start -> compute_finish = N_IN*N_OUT/LANES + 2 cycles.
//  acc range is +/-N_IN, so ACC_W never overflows; acc==0 gives bit 1.
//  x_we/w_we are 0 in every state except LOAD.
//  Async reset mid-RUN: back to IDLE immediately, no res_valid; memory contents are kept.
// CONFIGURATION
//  NN_ACC_OUT_EN defined: adds port acc_out out LANES*ACC_W, lane k at [k*ACC_W +: ACC_W],
//   valid with res_valid, otherwise holds its last value.
//  Not defined: no port; acc is used only for the sign bit.
// STRUCTURE
//  Package nn_pkg: state encoding (IDLE/LOAD/RUN/DRAIN/DONE) and the ACC_W/capacity
//   function of N_IN, N_OUT and LANES.
//  Sub-module nn_xnor_acc: LANES-wide XNOR +/-1 accumulator with clear and enable.
//  Top: FSM, counters and memory-port drive.
// TESTING (N_IN=4, N_OUT=4, LANES=2)
//  Load x=1011, w words {11,00,10,01,...}: 4 x writes and 8 w writes at addr 0..3 / 0..7, ld_ovf=0.
//  9th w beat -> ld_ready=0, no w_we, ld_ovf=1 and stays 1.
//  start with all-match data -> res_data=11, group 0 then 1, compute_finish at start+10.
//  Two matches and two mismatches (acc=0) -> bit 1; all mismatch -> bit 0.
//  Reset pulse mid-RUN -> IDLE, no res_valid; start again gives the correct results.
//  With NN_ACC_OUT_EN: all-match group -> acc_out lanes = +4, all-mismatch -> -4.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the binary fully-connected layer engine: FSM state
// encoding and the width/capacity helpers derived from the layer shape.
package nn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Signed accumulator width able to hold +/-n_in.
    function automatic int unsigned acc_width(input int unsigned n_in);
        return $clog2(n_in) + 2;
    endfunction

    // Number of LANES-wide w words that make up the whole layer.
    function automatic int unsigned w_capacity(input int unsigned n_in,
                                               input int unsigned n_out,
                                               input int unsigned lanes);
        return (n_in * n_out) / lanes;
    endfunction

    // Bits needed to index 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_xnor_acc.sv
// LANES-wide XNOR accumulator: each enabled beat adds +1 to a lane when x
// matches that lane's weight bit and -1 otherwise. clr restarts from zero on
// the same beat. Optional NN_ACC_OUT_EN exposes the next accumulator value.
module nn_xnor_acc
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             x,
    input  logic [LANES-1:0] w,
    output logic [LANES-1:0] sign_c
`ifdef NN_ACC_OUT_EN
    ,
    output logic [LANES*ACC_W-1:0] acc_next_c
`endif
);

    logic [LANES-1:0][ACC_W-1:0] acc;
    logic [LANES-1:0][ACC_W-1:0] acc_nxt;

    // Next accumulator per lane and its non-negative flag.
    always_comb begin
        acc_nxt = '0;
        sign_c  = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            acc_nxt[k] = (clr ? ACC_W'(0) : acc[k])
                       + ((x == w[k]) ? ACC_W'(1) : {ACC_W{1'b1}});
            sign_c[k]  = ~acc_nxt[k][ACC_W-1];
        end
    end

`ifdef NN_ACC_OUT_EN
    assign acc_next_c = acc_nxt;
`endif

    // Accumulator register, advanced only on beats carrying valid data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/nn_layer_engine.sv
// Binary fully-connected layer engine. Loads x/w memories through a
// valid/ready port, then streams an XNOR-popcount pass over LANES neurons
// at a time and emits one sign word per neuron group.
// Optional feature: define NN_ACC_OUT_EN to expose the raw lane accumulators.
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter int unsigned N_IN       = 784,
    parameter int unsigned N_OUT      = 16,
    parameter int unsigned LANES      = 4,
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned W_ADDR_LEN = 20
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load_en,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic                               ld_sel,
    input  logic [LANES-1:0]                   ld_data,
    output logic                               ld_ovf,
    input  logic                               start,
    output logic                               x_we,
    output logic                               w_we,
    output logic [X_ADDR_LEN-1:0]              x_addr,
    output logic [W_ADDR_LEN-1:0]              w_addr,
    output logic                               x_wdata,
    output logic [LANES-1:0]                   w_wdata,
    input  logic                               x_rdata,
    input  logic [LANES-1:0]                   w_rdata,
    output logic                               res_valid,
    output logic [cnt_width(N_OUT/LANES)-1:0]  res_group,
    output logic [LANES-1:0]                   res_data,
    output logic                               busy,
    output logic                               compute_finish
`ifdef NN_ACC_OUT_EN
    ,
    output logic [LANES*acc_width(N_IN)-1:0]   acc_out
`endif
);

    localparam int unsigned ACC_W  = acc_width(N_IN);
    localparam int unsigned N_GRP  = N_OUT / LANES;
    localparam int unsigned GRP_W  = cnt_width(N_GRP);
    localparam int unsigned W_CAP  = w_capacity(N_IN, N_OUT, LANES);
    localparam int unsigned I_W    = cnt_width(N_IN);
    localparam int unsigned XC_W   = $clog2(N_IN + 1);
    localparam int unsigned WC_W   = $clog2(W_CAP + 1);
    localparam logic [I_W-1:0]   I_LAST = I_W'(N_IN - 1);
    localparam logic [GRP_W-1:0] G_LAST = GRP_W'(N_GRP - 1);

    state_t            state;
    logic [XC_W-1:0]   x_cnt;
    logic [WC_W-1:0]   w_cnt;
    logic [I_W-1:0]    cur_i;
    logic [GRP_W-1:0]  cur_g;
    logic              iss_valid;
    logic              dat_valid;
    logic              dat_first;
    logic              dat_last;
    logic [GRP_W-1:0]  dat_group;
    logic              x_room;
    logic              w_room;
    logic [LANES-1:0]  sign_c;
`ifdef NN_ACC_OUT_EN
    logic [LANES*ACC_W-1:0] acc_next_c;
`endif

    // Load handshake: only while loading and the selected memory has room.
    assign x_room   = (x_cnt < XC_W'(N_IN));
    assign w_room   = (w_cnt < WC_W'(W_CAP));
    assign ld_ready = (state == ST_LOAD) && load_en && (ld_sel ? w_room : x_room);

    nn_xnor_acc #(
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clr        (dat_first),
        .en         (dat_valid),
        .x          (x_rdata),
        .w          (w_rdata),
        .sign_c     (sign_c)
`ifdef NN_ACC_OUT_EN
        ,
        .acc_next_c (acc_next_c)
`endif
    );

    // Phase FSM with load counters, read-address sequencing and result strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            x_cnt          <= '0;
            w_cnt          <= '0;
            cur_i          <= '0;
            cur_g          <= '0;
            iss_valid      <= 1'b0;
            dat_valid      <= 1'b0;
            dat_first      <= 1'b0;
            dat_last       <= 1'b0;
            dat_group      <= '0;
            ld_ovf         <= 1'b0;
            x_we           <= 1'b0;
            w_we           <= 1'b0;
            x_addr         <= '0;
            w_addr         <= '0;
            x_wdata        <= 1'b0;
            w_wdata        <= '0;
            res_valid      <= 1'b0;
            res_group      <= '0;
            res_data       <= '0;
            busy           <= 1'b0;
            compute_finish <= 1'b0;
        end else begin
            x_we      <= 1'b0;
            w_we      <= 1'b0;
            res_valid <= 1'b0;
            // Read data lands one cycle after its address was issued.
            dat_valid <= iss_valid;
            dat_first <= (cur_i == '0);
            dat_last  <= (cur_i == I_LAST);
            dat_group <= cur_g;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_en) begin
                        state          <= ST_LOAD;
                        busy           <= 1'b1;
                        compute_finish <= 1'b0;
                        x_cnt          <= '0;
                        w_cnt          <= '0;
                    end else if (start) begin
                        state          <= ST_RUN;
                        busy           <= 1'b1;
                        compute_finish <= 1'b0;
                        cur_i          <= '0;
                        cur_g          <= '0;
                        x_addr         <= '0;
                        w_addr         <= '0;
                        iss_valid      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!load_en) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    if (ld_valid && ld_ready) begin
                        if (ld_sel) begin
                            w_we    <= 1'b1;
                            w_addr  <= W_ADDR_LEN'(w_cnt);
                            w_wdata <= ld_data;
                            w_cnt   <= w_cnt + WC_W'(1);
                        end else begin
                            x_we    <= 1'b1;
                            x_addr  <= X_ADDR_LEN'(x_cnt);
                            x_wdata <= ld_data[0];
                            x_cnt   <= x_cnt + XC_W'(1);
                        end
                    end else if (load_en && ld_valid) begin
                        ld_ovf <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if ((cur_i == I_LAST) && (cur_g == G_LAST)) begin
                        state     <= ST_DRAIN;
                        iss_valid <= 1'b0;
                    end else begin
                        iss_valid <= 1'b1;
                        w_addr    <= w_addr + W_ADDR_LEN'(1);
                        if (cur_i == I_LAST) begin
                            cur_i  <= '0;
                            cur_g  <= cur_g + GRP_W'(1);
                            x_addr <= '0;
                        end else begin
                            cur_i  <= cur_i + I_W'(1);
                            x_addr <= X_ADDR_LEN'(cur_i + I_W'(1));
                        end
                    end
                end
                ST_DRAIN: begin
                    state          <= ST_DONE;
                    busy           <= 1'b0;
                    compute_finish <= 1'b1;
                end
                default: begin
                    state          <= ST_IDLE;
                    busy           <= 1'b0;
                    compute_finish <= 1'b0;
                    iss_valid      <= 1'b0;
                end
            endcase

            if (dat_valid && dat_last) begin
                res_valid <= 1'b1;
                res_group <= dat_group;
                res_data  <= sign_c;
            end
        end
    end

`ifdef NN_ACC_OUT_EN
    // Raw accumulators captured alongside each result word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_out <= '0;
        end else if (dat_valid && dat_last) begin
            acc_out <= acc_next_c;
        end
    end
`endif

endmodule

// File: tb/tb_nn_layer_engine.sv
// Self-checking bench for nn_layer_engine (N_IN=4, N_OUT=4, LANES=2).
// Checks against a behavioural layer model; NN_ACC_OUT_EN adds acc_out checks.
module tb_nn_layer_engine;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned LANES = 2;
    localparam int unsigned XAL   = 4;
    localparam int unsigned WAL   = 4;
    localparam int unsigned G     = N_OUT / LANES;
    localparam int unsigned B     = N_IN * G;
    localparam int unsigned ACC_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   load_en, ld_valid, ld_ready, ld_sel, ld_ovf, start;
    logic [LANES-1:0]       ld_data;
    logic                   x_we, w_we, x_wdata, x_rdata;
    logic [XAL-1:0]         x_addr;
    logic [WAL-1:0]         w_addr;
    logic [LANES-1:0]       w_wdata, w_rdata;
    logic                   res_valid, busy, compute_finish;
    logic [0:0]             res_group;
    logic [LANES-1:0]       res_data;
`ifdef NN_ACC_OUT_EN
    logic [LANES*ACC_W-1:0] acc_out;
`endif

    nn_layer_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .X_ADDR_LEN(XAL), .W_ADDR_LEN(WAL)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_data(ld_data), .ld_ovf(ld_ovf), .start(start),
        .x_we(x_we), .w_we(w_we), .x_addr(x_addr), .w_addr(w_addr),
        .x_wdata(x_wdata), .w_wdata(w_wdata), .x_rdata(x_rdata), .w_rdata(w_rdata),
        .res_valid(res_valid), .res_group(res_group), .res_data(res_data),
        .busy(busy), .compute_finish(compute_finish)
`ifdef NN_ACC_OUT_EN
        , .acc_out(acc_out)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency.
    logic             xmem [16];
    logic [LANES-1:0] wmem [16];
    initial for (int i = 0; i < 16; i++) begin xmem[i] = 1'b0; wmem[i] = '0; end
    always @(posedge clk) begin
        if (x_we) xmem[x_addr] <= x_wdata;
        if (w_we) wmem[w_addr] <= w_wdata;
        x_rdata <= xmem[x_addr];
        w_rdata <= wmem[w_addr];
    end

    typedef struct {
        int unsigned            cyc;
        int unsigned            grp;
        logic [LANES-1:0]       data;
        logic [LANES*ACC_W-1:0] acc;
    } ev_t;

    ev_t                    evq[$];
    int unsigned            n_chk = 0;
    int unsigned            n_err = 0;
    int unsigned            cyc = 0;
    int unsigned            run_s = 0;
    int unsigned            cf_cyc = 0;
    bit                     cf_seen, run_on, in_load, mon_on, m_exp;
    bit                     ovf_exp;
    int unsigned            xcnt, wcnt;
    logic                   mx [N_IN];
    logic [LANES-1:0]       mw [B];
    logic [LANES-1:0]       last_res [G];
    logic [LANES*ACC_W-1:0] last_acc [G];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Layer model: for every group and lane, sum +1 per match, -1 per mismatch.
    function automatic void push_run(input int unsigned s);
        ev_t e;
        int  a;
        for (int g = 0; g < int'(G); g++) begin
            e.cyc  = s + (g + 1) * N_IN + 2;
            e.grp  = g;
            e.data = '0;
            e.acc  = '0;
            for (int k = 0; k < int'(LANES); k++) begin
                a = 0;
                for (int i = 0; i < int'(N_IN); i++)
                    a += (mx[i] == mw[g * N_IN + i][k]) ? 1 : -1;
                e.data[k] = (a >= 0);
                e.acc[k*ACC_W +: ACC_W] = ACC_W'(a);
            end
            evq.push_back(e);
        end
    endfunction

    // Per-cycle comparison of result stream, run status and write enables.
    always @(negedge clk) begin
        if (rst && mon_on) begin
            m_exp = (evq.size() > 0) && (evq[0].cyc == cyc);
            chk("res_valid", 32'(res_valid), 32'(m_exp));
            if (m_exp) begin
                chk("res_group", 32'(res_group), evq[0].grp);
                chk("res_data", 32'(res_data), 32'(evq[0].data));
                last_res[evq[0].grp] = res_data;
`ifdef NN_ACC_OUT_EN
                chk("acc_out", 32'(acc_out), 32'(evq[0].acc));
                last_acc[evq[0].grp] = acc_out;
`endif
                void'(evq.pop_front());
            end
            if (run_on && cyc > run_s) begin
                chk("busy_run", 32'(busy), 32'(cyc <= run_s + B + 1));
                chk("compute_finish", 32'(compute_finish), 32'(cyc >= run_s + B + 2));
                if (compute_finish && !cf_seen) begin
                    cf_seen = 1'b1;
                    cf_cyc  = cyc;
                end
            end
            if (!in_load)
                chk("we_outside_load", 32'({x_we, w_we}), 32'(0));
        end
    end

    task automatic load_start(input bit with_start);
        run_on  = 1'b0;
        in_load = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b1;
        start   = with_start;
        @(posedge clk); #1;
        start = 1'b0;
        xcnt  = 0;
        wcnt  = 0;
        @(negedge clk);
        chk("busy_load", 32'(busy), 32'(1));
    endtask

    task automatic load_stop();
        @(posedge clk); #1;
        load_en = 1'b0;
        ld_sel  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'(0));
        chk("ld_ready_idle", 32'(ld_ready), 32'(0));
        in_load = 1'b0;
    endtask

    task automatic beat(input logic sel, input logic [LANES-1:0] d);
        logic acc_exp;
        acc_exp = sel ? (wcnt < B) : (xcnt < N_IN);
        @(posedge clk); #1;
        ld_sel   = sel;
        ld_data  = d;
        ld_valid = 1'b1;
        @(negedge clk);
        chk("ld_ready", 32'(ld_ready), 32'(acc_exp));
        @(posedge clk); #1;
        ld_valid = 1'b0;
        @(negedge clk);
        chk("x_we", 32'(x_we), 32'(!sel && acc_exp));
        chk("w_we", 32'(w_we), 32'(sel && acc_exp));
        if (acc_exp) begin
            if (sel) begin
                chk("w_addr", 32'(w_addr), wcnt);
                chk("w_wdata", 32'(w_wdata), 32'(d));
                mw[wcnt] = d;
                wcnt++;
            end else begin
                chk("x_addr", 32'(x_addr), xcnt);
                chk("x_wdata", 32'(x_wdata), 32'(d[0]));
                mx[xcnt] = d[0];
                xcnt++;
            end
        end else begin
            ovf_exp = 1'b1;
        end
        chk("ld_ovf", 32'(ld_ovf), 32'(ovf_exp));
    endtask

    // Full x then w load (or randomly interleaved), inside an open load phase.
    task automatic load_all(input logic [N_IN-1:0] xv, input logic [LANES*B-1:0] wv, input bit mix);
        int unsigned xi, wi;
        logic s;
        xi = 0;
        wi = 0;
        while (xi < N_IN || wi < B) begin
            if (xi == N_IN) s = 1'b1;
            else if (wi == B || !mix) s = 1'b0;
            else s = 1'($urandom_range(1));
            if (s) begin
                beat(1'b1, wv[wi*LANES +: LANES]);
                wi++;
            end else begin
                beat(1'b0, {1'($urandom_range(1)), xv[xi]});
                xi++;
            end
        end
    endtask

    task automatic run_layer();
        @(posedge clk); #1;
        start   = 1'b1;
        run_s   = cyc;
        cf_seen = 1'b0;
        run_on  = 1'b1;
        push_run(cyc);
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < int'(B) + 10 && evq.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        chk("results_pending", evq.size(), 32'(0));
        evq.delete();
    endtask

    logic [N_IN-1:0]     xv;
    logic [LANES*B-1:0]  wv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; load_en = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_data = '0; start = 1'b0;
        run_on = 1'b0; in_load = 1'b0; mon_on = 1'b0; ovf_exp = 1'b0; cf_seen = 1'b0;
        xcnt = 0; wcnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cf", 32'(compute_finish), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_ovf", 32'(ld_ovf), 32'(0));
        chk("rst_we", 32'({x_we, w_we}), 32'(0));
        chk("rst_addr", 32'({x_addr, w_addr}), 32'(0));
        chk("rst_ld_ready", 32'(ld_ready), 32'(0));
        @(posedge clk); #1;
        rst    = 1'b1;
        mon_on = 1'b1;

        // Directed load x=1011, w={11,00,10,01,...}, then overflow beats.
        xv = 4'b1101;
        for (int j = 0; j < int'(B); j++)
            case (j % 4)
                0: wv[j*LANES +: LANES] = 2'b11;
                1: wv[j*LANES +: LANES] = 2'b00;
                2: wv[j*LANES +: LANES] = 2'b10;
                default: wv[j*LANES +: LANES] = 2'b01;
            endcase
        load_start(1'b0);
        load_all(xv, wv, 1'b0);
        chk("ovf_full", 32'(ld_ovf), 32'(0));
        beat(1'b1, 2'b11);
        beat(1'b0, 2'b01);
        load_stop();
        chk("ovf_sticky", 32'(ld_ovf), 32'(1));
        run_layer();

        // All lanes match: every result bit 1, finish exactly 10 cycles after start.
        for (int j = 0; j < int'(B); j++) wv[j*LANES +: LANES] = {2{xv[j % N_IN]}};
        load_start(1'b0);
        load_all(xv, wv, 1'b0);
        load_stop();
        run_layer();
        chk("all_match_g0", 32'(last_res[0]), 32'(2'b11));
        chk("all_match_g1", 32'(last_res[1]), 32'(2'b11));
        chk("finish_latency", cf_cyc - run_s, 32'(10));
        chk("ovf_still_set", 32'(ld_ovf), 32'(1));

        // g0: lane0 all match, lane1 all mismatch; g1: lane0 balanced, lane1 all match.
        for (int i = 0; i < int'(N_IN); i++) begin
            wv[i*LANES +: LANES]          = {~xv[i], xv[i]};
            wv[(N_IN+i)*LANES +: LANES]   = {xv[i], (i < 2) ? xv[i] : ~xv[i]};
        end
        load_start(1'b0);
        load_all(xv, wv, 1'b1);
        load_stop();
        run_layer();
        chk("mixed_g0", 32'(last_res[0]), 32'(2'b01));
        chk("balanced_g1", 32'(last_res[1]), 32'(2'b11));
`ifdef NN_ACC_OUT_EN
        chk("acc_g0_pm4", 32'(last_acc[0]), 32'(8'hC4));
        chk("acc_g1_0p4", 32'(last_acc[1]), 32'(8'h40));
`endif

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        start  = 1'b1;
        run_on = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_res_valid", 32'(res_valid), 32'(0));
        chk("midrst_addr", 32'({x_addr, w_addr}), 32'(0));
        @(posedge clk); #1;
        rst     = 1'b1;
        ovf_exp = 1'b0;
        @(negedge clk);
        chk("midrst_ovf_clr", 32'(ld_ovf), 32'(0));
        run_layer();
        chk("rerun_g0", 32'(last_res[0]), 32'(2'b01));

        // Randomised layers; first load also raises start with load_en from DONE.
        for (int it = 0; it < 6; it++) begin
            xv = N_IN'($urandom);
            for (int j = 0; j < int'(B); j++) wv[j*LANES +: LANES] = LANES'($urandom);
            load_start(it == 0);
            load_all(xv, wv, 1'b1);
            if (it == 3) beat(1'b0, 2'b10);
            load_stop();
            run_layer();
            if (it == 2) run_layer();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
